// File: rtl/vr_burst_source.sv
// Valid/ready burst source: takes a (base, step, len) command and emits
// len+1 beats of the arithmetic sequence base, base+step, ... downstream.
module vr_burst_source #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_base,
    input  logic [WIDTH-1:0] cmd_step,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    input  logic             ready_down_in,
    output logic             last_out,
    output logic             done_out,
    output logic             busy_out
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; once valid is raised, valid/data/last hold until that edge.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] step_q;
    logic [LEN_W-1:0] remaining_q;
    logic             last_q;
    logic             done_q;
    logic             load;
    logic             advance;
    logic             finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // In SEND valid is high, so a downstream transfer is just ready_down_in.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SEND;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (ready_down_in) begin
                    if (remaining_q == '0) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            step_q      <= '0;
            remaining_q <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                data_q      <= cmd_base;
                step_q      <= cmd_step;
                remaining_q <= cmd_len;
                last_q      <= (cmd_len == '0);
            end else if (advance) begin
                data_q      <= data_q + step_q;
                remaining_q <= remaining_q - 1'b1;
                last_q      <= (remaining_q == LEN_W'(1));
            end else if (finish) begin
                last_q <= 1'b0;
            end
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign busy_out       = (state_q == SEND);
    assign valid_down_out = (state_q == SEND);
    assign data_out       = data_q;
    assign last_out       = last_q;
    assign done_out       = done_q;

endmodule

// File: tb/tb_vr_burst_source.sv
// Bench for vr_burst_source: table of bursts plus random bursts checked
// beat-by-beat against an arithmetic-sequence model, and hand-written corners.
module tb_vr_burst_source;

  localparam int WIDTH = 32;
  localparam int LEN_W = 8;
  localparam int MAX_CYC = 2000;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_base;
  logic [WIDTH-1:0] cmd_step;
  logic [LEN_W-1:0] cmd_len;
  logic [WIDTH-1:0] data_out;
  logic             valid_down_out;
  logic             ready_down_in;
  logic             last_out;
  logic             done_out;
  logic             busy_out;

  int errors = 0;
  int checks = 0;

  vr_burst_source #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_base       (cmd_base),
    .cmd_step       (cmd_step),
    .cmd_len        (cmd_len),
    .data_out       (data_out),
    .valid_down_out (valid_down_out),
    .ready_down_in  (ready_down_in),
    .last_out       (last_out),
    .done_out       (done_out),
    .busy_out       (busy_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] step;
    logic [LEN_W-1:0] len;
    int               stall_pct;
    logic [7:0]       pat;
    int               pat_len;
    int               exp_beats;
    logic [WIDTH-1:0] exp_final;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge with the block idle. The command fires on the next
  // posedge; the task returns at the negedge of the done_out cycle.
  task automatic run_burst(input logic [WIDTH-1:0] base, input logic [WIDTH-1:0] step,
                           input logic [LEN_W-1:0] len, input int stall_pct,
                           input logic [7:0] pat, input int pat_len, input bit hold_valid,
                           output int beats, output logic [WIDTH-1:0] final_data);
    logic [WIDTH-1:0] exp_q[$];
    bit               exp_last_q[$];
    logic [WIDTH-1:0] hold_d;
    logic             hold_l;
    bit               stalled;
    int               cyc;
    logic [WIDTH-1:0] exp_d;
    bit               exp_l;
    for (int k = 0; k <= int'(len); k++) begin
      exp_q.push_back(base + step * WIDTH'(k));
      exp_last_q.push_back(k == int'(len));
    end
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid     = 1'b1;
    cmd_base      = base;
    cmd_step      = step;
    cmd_len       = len;
    ready_down_in = 1'($urandom_range(1));
    @(negedge clk);
    beats = 0;
    cyc = 0;
    stalled = 0;
    final_data = '0;
    while (exp_q.size() > 0 && cyc < MAX_CYC) begin
      if (hold_valid) begin
        cmd_base = $urandom;
        cmd_step = $urandom;
        cmd_len  = LEN_W'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      check("valid_in_send", {31'd0, valid_down_out}, 32'd1);
      check("cmd_ready_send", {31'd0, cmd_ready}, 32'd0);
      check("busy_send", {31'd0, busy_out}, 32'd1);
      if (stalled) begin
        check("stall_hold_data", data_out, hold_d);
        check("stall_hold_last", {31'd0, last_out}, {31'd0, hold_l});
      end
      if (pat_len > 0) ready_down_in = (cyc < pat_len) ? pat[cyc] : 1'b1;
      else ready_down_in = (int'($urandom_range(99)) >= stall_pct);
      if (ready_down_in) begin
        exp_d = exp_q.pop_front();
        exp_l = exp_last_q.pop_front();
        check("beat_data", data_out, exp_d);
        check("beat_last", {31'd0, last_out}, {31'd0, exp_l});
        final_data = data_out;
        beats++;
        stalled = 0;
      end else begin
        stalled = 1;
        hold_d = data_out;
        hold_l = last_out;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= MAX_CYC) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got %0d beats expected %0d", beats, int'(len) + 1);
    end
    ready_down_in = 1'($urandom_range(1));
    check("done_pulse", {31'd0, done_out}, 32'd1);
    check("valid_after_last", {31'd0, valid_down_out}, 32'd0);
    check("cmd_ready_after_last", {31'd0, cmd_ready}, 32'd1);
    check("busy_after_last", {31'd0, busy_out}, 32'd0);
  endtask

  task automatic finish_burst();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("done_clears", {31'd0, done_out}, 32'd0);
    check("idle_valid_low", {31'd0, valid_down_out}, 32'd0);
  endtask

  initial begin
    int               beats;
    logic [WIDTH-1:0] fin;
    logic [LEN_W-1:0] rlen;
    logic [WIDTH-1:0] rbase;
    logic [WIDTH-1:0] rstep;

    // base, step, len, stall%, pattern, pattern length, beats, final word
    vecs[0] = '{32'h10,       32'h1,        8'd3,   0, 8'h00,     0, 4,   32'h13};
    vecs[1] = '{32'hAA,       32'h5,        8'd0,   0, 8'h00,     0, 1,   32'hAA};
    vecs[2] = '{32'h0,        32'h4,        8'd2,   0, 8'b101001, 6, 3,   32'h8};
    vecs[3] = '{32'hFFFFFFFE, 32'h1,        8'hFF,  0, 8'h00,     0, 256, 32'hFD};
    vecs[4] = '{32'h1234,     32'hFFFFFFF0, 8'd9,  40, 8'h00,     0, 10,  32'h11A4};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_base = '0;
    cmd_step = '0;
    cmd_len = '0;
    ready_down_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_valid", {31'd0, valid_down_out}, 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_last", {31'd0, last_out}, 32'd0);
    check("rst_done", {31'd0, done_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);

    foreach (vecs[i]) begin
      run_burst(vecs[i].base, vecs[i].step, vecs[i].len, vecs[i].stall_pct,
                vecs[i].pat, vecs[i].pat_len, 1'b0, beats, fin);
      check("vec_beats", WIDTH'(beats), WIDTH'(vecs[i].exp_beats));
      check("vec_final", fin, vecs[i].exp_final);
      finish_burst();
    end

    // back-to-back: A holds cmd_valid with junk fields, B accepted in done cycle
    run_burst(32'h100, 32'h2, 8'd1, 0, 8'h00, 0, 1'b1, beats, fin);
    check("b2b_a_final", fin, 32'h102);
    run_burst(32'h5000, 32'h3, 8'd2, 0, 8'h00, 0, 1'b0, beats, fin);
    check("b2b_b_beats", WIDTH'(beats), 32'd3);
    check("b2b_b_final", fin, 32'h5006);
    finish_burst();

    for (int r = 0; r < 10; r++) begin
      rbase = $urandom;
      rstep = $urandom;
      rlen  = LEN_W'($urandom_range(20));
      run_burst(rbase, rstep, rlen, int'($urandom_range(50)), 8'h00, 0, 1'b0, beats, fin);
      check("rand_beats", WIDTH'(beats), WIDTH'(rlen) + 32'd1);
      check("rand_final", fin, rbase + rstep * WIDTH'(rlen));
      finish_burst();
    end

    // mid-burst reset during beat 2 of a 6-beat burst
    cmd_valid = 1'b1;
    cmd_base = 32'h40;
    cmd_step = 32'h10;
    cmd_len = 8'd5;
    ready_down_in = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mr_beat0", data_out, 32'h40);
    @(negedge clk);
    check("mr_beat1", data_out, 32'h50);
    @(negedge clk);
    check("mr_beat2", data_out, 32'h60);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", {31'd0, valid_down_out}, 32'd0);
    check("mr_data", data_out, 32'd0);
    check("mr_last", {31'd0, last_out}, 32'd0);
    check("mr_busy", {31'd0, busy_out}, 32'd0);
    check("mr_done", {31'd0, done_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mr_no_done", {31'd0, done_out}, 32'd0);
      check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    end
    run_burst(32'h7, 32'h7, 8'd4, 20, 8'h00, 0, 1'b0, beats, fin);
    check("mr_new_beats", WIDTH'(beats), 32'd5);
    check("mr_new_final", fin, 32'h23);
    finish_burst();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
